// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction RAM read port plus the decoder valid/ready handshake.
// The fetch unit connects through the master modport, the RAM and decoder through the slave modport.
interface fetch_if;
  logic [29:0] ram_addr;
  logic        ram_re;
  logic [31:0] ram_dout;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  modport master (
    output ram_addr, ram_re, instr, instr_pc, instr_valid, fetch_count,
    input  ram_dout, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  ram_addr, ram_re, instr, instr_pc, instr_valid, fetch_count,
    output ram_dout, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a 1-cycle registered-read RAM.
// It issues one read per cycle while the decoder accepts, and restarts at a new PC on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic {FETCH, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] redir_pc;
  logic        re;
  logic [29:0] addr;
  logic        handshake;

  assign redir_pc  = bus.redirect_pc & ~32'd3;
  assign handshake = (state_q == RESP) && bus.instr_ready && !reset;

  always_comb begin
    re         = 1'b0;
    addr       = pc_q[31:2];
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    count_d    = handshake ? count_q + 32'd1 : count_q;
    if (reset) begin
      addr = '0;
    end else if (bus.redirect) begin
      re         = 1'b1;
      addr       = redir_pc[31:2];
      instr_pc_d = redir_pc;
      pc_d       = redir_pc + 32'd4;
      state_d    = RESP;
    end else if (state_q == FETCH || bus.instr_ready) begin
      re         = 1'b1;
      instr_pc_d = pc_q;
      pc_d       = pc_q + 32'd4;
      state_d    = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
    end
  end

  // instr is the RAM output itself; holding ram_re low keeps it stable during a stall.
  assign bus.ram_re      = re;
  assign bus.ram_addr    = addr;
  assign bus.instr       = bus.ram_dout;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = (state_q == RESP) && !reset;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a 4-word 1-cycle RAM model, scenario tasks with inline checks,
// and a scoreboard of expected (pc, word) pairs popped on every accepted handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ram_q;
  logic [31:0] mem [4];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.instr_ready = ready;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;
  assign bus.ram_dout    = ram_q;

  always @(posedge clk) begin
    if (bus.ram_re) ram_q <= mem[bus.ram_addr[1:0]];
  end

  // Scoreboard: every accepted transfer must match the next expected entry.
  always @(negedge clk) begin
    #2;
    if (!reset && bus.instr_valid && ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%08h instr=%08h, expected no transfer", bus.instr_pc, bus.instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.instr_pc !== e.pc || bus.instr !== e.word) begin
          n_fail++;
          $display("FAIL sb_transfer: got pc=%08h instr=%08h, expected pc=%08h instr=%08h",
                   bus.instr_pc, bus.instr, e.pc, e.word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc = pc;
    e.word = word;
    sb.push_back(e);
  endtask

  // Leaves the caller at a negedge with reset still asserted.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (bus.ram_re !== 1'b0) begin n_fail++; $display("FAIL rst_re: got %b, expected 0", bus.ram_re); end
    n_checks++; if (bus.ram_addr !== 30'd0) begin n_fail++; $display("FAIL rst_addr: got %h, expected 0", bus.ram_addr); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", bus.instr_valid); end
    n_checks++; if (bus.fetch_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d, expected 0", bus.fetch_count); end
    n_checks++; if (bus.instr_pc !== 32'd0) begin n_fail++; $display("FAIL rst_instr_pc: got %h, expected 0", bus.instr_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    reset = 1'b0; ready = 1'b1;
    push_exp(32'h0, 32'h0020_0093);
    push_exp(32'h4, 32'h0030_0113);
    push_exp(32'h8, 32'h0011_01b3);
    push_exp(32'hC, 32'h0010_0073);
    #1;
    n_checks++; if (bus.ram_re !== 1'b1 || bus.ram_addr !== 30'd0) begin n_fail++; $display("FAIL stream_first_read: got re=%b addr=%h, expected re=1 addr=0", bus.ram_re, bus.ram_addr); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_cyc0_valid: got %b, expected 0", bus.instr_valid); end
    repeat (4) @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_checks++; if (bus.fetch_count !== 32'd4) begin n_fail++; $display("FAIL stream_count: got %0d, expected 4", bus.fetch_count); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stream_drain: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_stall();
    do_reset();
    reset = 1'b0; ready = 1'b1;
    push_exp(32'h0, 32'h0020_0093);
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++; if (bus.ram_re !== 1'b0) begin n_fail++; $display("FAIL stall_re[%0d]: got %b, expected 0", i, bus.ram_re); end
      n_checks++; if (bus.instr !== 32'h0030_0113 || bus.instr_pc !== 32'h4 || bus.instr_valid !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got instr=%08h pc=%08h v=%b, expected 00300113/4/1", i, bus.instr, bus.instr_pc, bus.instr_valid); end
      n_checks++; if (bus.fetch_count !== 32'd1) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d, expected 1", i, bus.fetch_count); end
    end
    @(negedge clk);
    ready = 1'b1;
    push_exp(32'h4, 32'h0030_0113);
    #1;
    n_checks++; if (bus.ram_re !== 1'b1 || bus.ram_addr !== 30'd2) begin n_fail++; $display("FAIL stall_resume_read: got re=%b addr=%h, expected re=1 addr=2", bus.ram_re, bus.ram_addr); end
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_checks++; if (bus.instr_pc !== 32'h8 || bus.instr !== 32'h0011_01b3) begin n_fail++; $display("FAIL stall_next: got pc=%08h instr=%08h, expected 8/001101b3", bus.instr_pc, bus.instr); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_redirect();
    do_reset();
    reset = 1'b0;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_000B;
    #1;
    n_checks++; if (bus.ram_re !== 1'b1 || bus.ram_addr !== 30'd2) begin n_fail++; $display("FAIL redir_read: got re=%b addr=%h, expected re=1 addr=2", bus.ram_re, bus.ram_addr); end
    @(negedge clk);
    redirect = 1'b0; ready = 1'b1;
    push_exp(32'h8, 32'h0011_01b3);
    push_exp(32'hC, 32'h0010_0073);
    #1;
    n_checks++; if (bus.instr_pc !== 32'h8 || bus.instr !== 32'h0011_01b3) begin n_fail++; $display("FAIL redir_target: got pc=%08h instr=%08h, expected 8/001101b3", bus.instr_pc, bus.instr); end
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_checks++; if (bus.fetch_count !== 32'd2 || bus.instr_pc !== 32'h10) begin n_fail++; $display("FAIL redir_flush: got count=%0d pc=%08h, expected 2/00000010", bus.fetch_count, bus.instr_pc); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL redir_drain: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_redirect_handshake();
    do_reset();
    reset = 1'b0; ready = 1'b1;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_000C;
    push_exp(32'h0, 32'h0020_0093);
    push_exp(32'hC, 32'h0010_0073);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_checks++; if (bus.fetch_count !== 32'd1) begin n_fail++; $display("FAIL rh_count: got %0d, expected 1", bus.fetch_count); end
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_checks++; if (bus.fetch_count !== 32'd2 || bus.instr_pc !== 32'h10) begin n_fail++; $display("FAIL rh_after: got count=%0d pc=%08h, expected 2/00000010", bus.fetch_count, bus.instr_pc); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rh_drain: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    reset = 1'b0; ready = 1'b1;
    push_exp(32'h0, 32'h0020_0093);
    push_exp(32'h4, 32'h0030_0113);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (bus.instr_pc !== 32'h8) begin n_fail++; $display("FAIL mid_pre_pc: got %08h, expected 00000008", bus.instr_pc); end
    n_checks++; if (bus.ram_re !== 1'b0) begin n_fail++; $display("FAIL mid_re: got %b, expected 0", bus.ram_re); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.ram_re !== 1'b0 || bus.fetch_count !== 32'd0)
      begin n_fail++; $display("FAIL mid_held: got v=%b re=%b count=%0d, expected 0/0/0", bus.instr_valid, bus.ram_re, bus.fetch_count); end
    @(negedge clk);
    reset = 1'b0;
    push_exp(32'h0, 32'h0020_0093);
    #1;
    n_checks++; if (bus.ram_re !== 1'b1 || bus.ram_addr !== 30'd0 || bus.instr_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_restart: got re=%b addr=%h v=%b, expected 1/0/0", bus.ram_re, bus.ram_addr, bus.instr_valid); end
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mid_drain: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    reset = 1'b0; ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC, 32'h0010_0073);
    push_exp(32'h0000_0000, 32'h0020_0093);
    #1;
    n_checks++; if (bus.ram_re !== 1'b1 || bus.ram_addr !== 30'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_read: got re=%b addr=%h, expected 1/3fffffff", bus.ram_re, bus.ram_addr); end
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_checks++; if (bus.instr_pc !== 32'h4 || bus.fetch_count !== 32'd2) begin n_fail++; $display("FAIL wrap_after: got pc=%08h count=%0d, expected 00000004/2", bus.instr_pc, bus.fetch_count); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d pending, expected 0", sb.size()); end
  endtask

  initial begin
    mem[0] = 32'h0020_0093;
    mem[1] = 32'h0030_0113;
    mem[2] = 32'h0011_01b3;
    mem[3] = 32'h0010_0073;
    reset = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_handshake();
    test_reset_midstream();
    test_wrap();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
